// File: rtl/div_unit_if.sv
// Divide handshake between the execute stage (master) and the divider (slave).
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             div_enable;
    logic             div_sign;
    logic [WIDTH-1:0] div_src1;
    logic [WIDTH-1:0] div_src2;
    logic             div_ack;
    logic             div_complete;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;

    modport master (
        output div_enable, div_sign, div_src1, div_src2, div_ack,
        input  div_complete, div_quotient, div_remainder
    );

    modport slave (
        input  div_enable, div_sign, div_src1, div_src2, div_ack,
        output div_complete, div_quotient, div_remainder
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider, signed/unsigned, quotient and remainder.
// Results are held in DONE until the execute stage acknowledges hand-off.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    div_unit_if.slave   div
);
    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] dvs, quo, rem;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic [CNT_W-1:0] cnt;
    logic             q_neg, r_neg;
    logic             complete;

    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH:0]   rem_sh, trial;
    logic             fits, last;

    assign abs1 = (div.div_sign && div.div_src1[WIDTH-1]) ? -div.div_src1 : div.div_src1;
    assign abs2 = (div.div_sign && div.div_src2[WIDTH-1]) ? -div.div_src2 : div.div_src2;

    // Shifted partial remainder needs one extra bit before the trial subtract.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs};
    assign fits   = rem_sh >= {1'b0, dvs};
    assign last   = cnt == CNT_W'(WIDTH-1);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (div.div_enable) state_nxt = BUSY;
            BUSY: begin
                if (!div.div_enable) state_nxt = IDLE;
                else if (last)       state_nxt = FIX;
            end
            FIX:  state_nxt = div.div_enable ? DONE : IDLE;
            DONE: if (div.div_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        complete = 1'b0;
        if (state == DONE) complete = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvs         <= '0;
            quo         <= '0;
            rem         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (div.div_enable) begin
                    dvs   <= abs2;
                    quo   <= abs1;
                    rem   <= '0;
                    cnt   <= '0;
                    q_neg <= div.div_sign & (div.div_src1[WIDTH-1] ^ div.div_src2[WIDTH-1]);
                    r_neg <= div.div_sign & div.div_src1[WIDTH-1];
                end
                BUSY: begin
                    rem <= fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], fits};
                    cnt <= cnt + 1'b1;
                end
                // An abort in FIX leaves the previous results visible.
                FIX: if (div.div_enable) begin
                    quotient_q  <= q_neg ? -quo : quo;
                    remainder_q <= r_neg ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

    assign div.div_complete  = complete;
    assign div.div_quotient  = quotient_q;
    assign div.div_remainder = remainder_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: latency, results, hold, back-to-back, abort, reset.
module tb_div_unit;
    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(WIDTH)) dif ();

    div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .div   (dif)
    );

    int          errors = 0;
    int          checks = 0;
    res_t        sb[$];
    logic [31:0] last_q, last_r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        res_t   e;
        longint la, lb, lq, lr;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            return e;
        end
        if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = longint'({32'd0, a});
            lb = longint'({32'd0, b});
        end
        lq  = la / lb;
        lr  = la % lb;
        e.q = lq[31:0];
        e.r = lr[31:0];
        return e;
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
        dif.div_enable = 1'b1;
        dif.div_sign   = s;
        dif.div_src1   = a;
        dif.div_src2   = b;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!dif.div_complete && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!dif.div_complete) chk("timeout", 32'(dif.div_complete), 32'd1);
    endtask

    task automatic check_result(input string tag);
        res_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_q"}, dif.div_quotient, e.q);
        chk({tag, "_r"}, dif.div_remainder, e.r);
        last_q = e.q;
        last_r = e.r;
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input int hold);
        int cyc;
        @(negedge clk);
        start(a, b, s);
        sb.push_back(model(a, b, s));
        wait_done(cyc);
        chk({tag, "_lat"}, 32'(cyc), 32'd34);
        check_result(tag);
        for (int k = 0; k < hold; k++) begin
            dif.div_src1 = $urandom;
            dif.div_src2 = $urandom;
            @(negedge clk);
            chk({tag, "_hold_c"}, 32'(dif.div_complete), 32'd1);
            chk({tag, "_hold_q"}, dif.div_quotient, last_q);
            chk({tag, "_hold_r"}, dif.div_remainder, last_r);
        end
        dif.div_ack    = 1'b1;
        dif.div_enable = 1'b0;
        @(negedge clk);
        dif.div_ack = 1'b0;
        chk({tag, "_drop"}, 32'(dif.div_complete), 32'd0);
    endtask

    initial begin
        int          cyc;
        logic        seen;
        logic [31:0] a, b;
        logic        s;

        reset          = 1'b1;
        dif.div_enable = 1'b0;
        dif.div_sign   = 1'b0;
        dif.div_src1   = '0;
        dif.div_src2   = '0;
        dif.div_ack    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_c", 32'(dif.div_complete), 32'd0);
        chk("rst_q", dif.div_quotient, 32'd0);
        chk("rst_r", dif.div_remainder, 32'd0);
        reset = 1'b0;

        run_div("u100_7",  32'd100,        32'd7,          1'b0, 0);
        run_div("sm7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 0);
        run_div("s7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 0);
        run_div("u80_3",   32'h8000_0000,  32'd3,          1'b0, 5);
        run_div("u_div0",  32'h1234_5678,  32'd0,          1'b0, 0);
        run_div("s_ovf",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 0);

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            s = 1'($urandom_range(0, 1));
            if (s && b == 32'd0) b = 32'd3;
            run_div($sformatf("rnd%0d", i), a, b, s, 0);
        end

        // Back-to-back: enable stays high across the ack.
        @(negedge clk);
        start(32'd1000, 32'd3, 1'b0);
        sb.push_back(model(32'd1000, 32'd3, 1'b0));
        wait_done(cyc);
        chk("b2b1_lat", 32'(cyc), 32'd34);
        check_result("b2b1");
        dif.div_ack  = 1'b1;
        dif.div_src1 = 32'd50;
        dif.div_src2 = 32'd5;
        sb.push_back(model(32'd50, 32'd5, 1'b0));
        @(negedge clk);
        dif.div_ack = 1'b0;
        chk("b2b_idle_c", 32'(dif.div_complete), 32'd0);
        wait_done(cyc);
        chk("b2b2_lat", 32'(cyc), 32'd34);
        check_result("b2b2");
        dif.div_ack    = 1'b1;
        dif.div_enable = 1'b0;
        @(negedge clk);
        dif.div_ack = 1'b0;
        chk("b2b2_drop", 32'(dif.div_complete), 32'd0);

        // Abort at BUSY cycle 10: no complete, old results kept.
        @(negedge clk);
        start(32'h0000_DEAD, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        dif.div_enable = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= dif.div_complete;
        end
        chk("abort_c", 32'(seen), 32'd0);
        chk("abort_q", dif.div_quotient, last_q);
        chk("abort_r", dif.div_remainder, last_r);

        // Reset at BUSY cycle 20.
        @(negedge clk);
        start(32'd12345, 32'd11, 1'b0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_c", 32'(dif.div_complete), 32'd0);
        chk("mrst_q", dif.div_quotient, 32'd0);
        chk("mrst_r", dif.div_remainder, 32'd0);
        reset          = 1'b0;
        dif.div_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_idle_c", 32'(dif.div_complete), 32'd0);

        run_div("post_rst", 32'hFFFF_FF9C, 32'd7, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider; the responder end of the execute stage's divide handshake (enable/sign/operands in, complete/results out).
- Computes quotient and remainder together with a radix-2 restoring algorithm, signed or unsigned.
- Holds results stable until the execute stage acknowledges hand-off, so the stage can stall on a downstream back-pressure without re-launching the divide.
- Sits beside the execute stage. The stage selects quotient (div) or remainder (mod) for its result path.

Parameters:
- WIDTH, 32, operand/result width; fixed at 32 for LA32, kept for bench scaling.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- div_enable  in  1  level request; high while a valid divide instruction occupies the execute stage
- div_sign  in  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu)
- div_src1  in  WIDTH  dividend (rj)
- div_src2  in  WIDTH  divisor (rk)
- div_ack  in  1  execute stage hands the instruction to memory this cycle (es_ready_go && ms_allowin)
- div_complete  out  1  results valid; level, held until acknowledged
- div_quotient  out  WIDTH  quotient
- div_remainder  out  WIDTH  remainder

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset values: state IDLE, div_complete 0, div_quotient 0, div_remainder 0, counter 0.
- Reset mid-operation: abort immediately; no stale complete after reset.
- FSM states: IDLE, BUSY, FIX, DONE.
- IDLE:
  - On div_enable=1, latch |src1| and |src2| (magnitude only when div_sign=1 and the MSB is set; else raw).
  - Latch q_neg = sign & (s1[31]^s2[31]) and r_neg = sign & s1[31].
  - Clear partial remainder and counter; go BUSY.
- BUSY:
  - One restoring step per cycle: shift {rem,quo} left 1, trial-subtract divisor from rem, keep if non-negative, set quotient LSB.
  - Counter increments each cycle. After WIDTH steps (counter==WIDTH-1 this cycle) go FIX.
- FIX:
  - Apply signs: quotient negated if q_neg, remainder negated if r_neg (two's complement, WIDTH bits, wrap).
  - Register into div_quotient/div_remainder; go DONE.
- DONE:
  - div_complete=1, outputs frozen.
  - On div_ack=1, go IDLE with div_complete=0 next cycle.
  - Operand changes in DONE are ignored.
- Latency: div_enable first sampled high in IDLE at cycle T gives div_complete=1 at cycle T+WIDTH+2 (T+34). Results are valid in the same cycle.
- Back-to-back divides: after ack, IDLE samples div_enable on the next cycle. A continuously high enable therefore launches the next instruction with no dead cycle beyond IDLE.
- Abort: div_enable=0 while in BUSY or FIX returns to IDLE; div_complete stays 0 and outputs keep their old values.
- div_ack outside DONE: ignored.
- Divide by zero: no trap. Result is quotient = all ones (unsigned-path output, then sign fix applied), remainder = dividend.
  - Bench expects q=0xFFFFFFFF, r=src1 for unsigned.
  - For signed, the natural restoring result after sign fix is the required value; no special-case logic.
- Signed overflow 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0. This falls out of the magnitude path with no special case.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Unsigned 100/7, sign=0, enable held, ack tied to complete -> complete exactly 34 cycles after first enable, q=14, r=2; complete drops the cycle after ack.
- Signed 0xFFFFFFF9 (-7) / 2, sign=1 -> q=0xFFFFFFFD, r=0xFFFFFFFF.
- Signed 7 / 0xFFFFFFFE (-2) -> q=0xFFFFFFFD, r=1.
- Unsigned 0x80000000/3 -> q=0x2AAAAAAA, r=2.
- Edge operands:
  - 0x12345678/0, sign=0 -> q=0xFFFFFFFF, r=0x12345678.
  - 0x80000000/0xFFFFFFFF, sign=1 -> q=0x80000000, r=0.
- Back-pressure, back-to-back, abort and reset:
  - Hold ack low 5 cycles after complete while changing src1/src2 -> complete and results stay constant.
  - Ack followed by a second divide 50/5 with enable kept high -> second complete 34 cycles after IDLE re-entry, q=10, r=0.
  - Enable dropped at BUSY cycle 10 -> IDLE, no complete.
  - Reset at BUSY cycle 20 -> all outputs 0 next cycle.
